// File: rtl/spi_matrix_tx_master.sv
// Streams NUM_WORDS 16-bit words from a synchronous SRAM onto SPI (MSB first),
// grouping up to FRAME_WORDS words per chip-select frame with a one-word prefetch.
module spi_matrix_tx_master #(
    parameter int NUM_WORDS   = 4096,
    parameter int FRAME_WORDS = 16,
    parameter int LEAD_CYCLES = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int ADDR_W      = 12
) (
    input  logic              spi_sclk,
    input  logic              sys_rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_rdata,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_sent
);

    localparam int LEAD_W = (LEAD_CYCLES > 1) ? $clog2(LEAD_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int WIF_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_WORDS - 1);
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(LEAD_CYCLES - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [WIF_W-1:0]  WIF_LAST  = WIF_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {IDLE, FETCH, LEAD, SHIFT, GAP, DONE} state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_word_idx;
    logic [WIF_W-1:0]    r_wif;
    logic [3:0]          r_bit_cnt;
    logic [LEAD_W-1:0]   r_lead_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [15:0]         r_shift;
    logic [15:0]         r_prefetch;
    logic [ADDR_W-1:0]   r_addr_hold;
    logic [ADDR_W:0]     r_words_sent;

    logic                w_last_in_frame;
    logic                w_is_last_word;
    logic                w_bit_end;
    logic                w_abort;
    logic [ADDR_W-1:0]   w_addr;

    assign w_is_last_word  = (r_word_idx == LAST_IDX);
    assign w_last_in_frame = (r_wif == WIF_LAST) || w_is_last_word;
    assign w_bit_end       = (r_bit_cnt == 4'd15);
    assign w_abort         = abort && (r_state != IDLE);
    assign words_sent      = r_words_sent;
    // Address is only meaningful while mem_re is high; otherwise show the last one issued.
    assign mem_addr        = mem_re ? w_addr : r_addr_hold;

    always_ff @(posedge spi_sclk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        mem_re   = 1'b0;
        w_addr   = r_word_idx;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        busy     = (r_state != IDLE);
        done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) w_next = FETCH;
            end
            FETCH: begin
                mem_re = 1'b1;
                w_next = LEAD;
            end
            LEAD: begin
                spi_cs_n = 1'b0;
                if (r_lead_cnt == LEAD_LAST) w_next = SHIFT;
            end
            SHIFT: begin
                spi_cs_n = 1'b0;
                spi_mosi = r_shift[15];
                if (r_bit_cnt == 4'd1 && !w_last_in_frame) begin
                    mem_re = 1'b1;
                    w_addr = r_word_idx + ADDR_W'(1);
                end
                if (w_bit_end && w_last_in_frame)
                    w_next = w_is_last_word ? DONE : GAP;
            end
            GAP: begin
                if (r_gap_cnt == GAP_LAST) w_next = FETCH;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    // Datapath freezes on abort so words_sent keeps the count of completed words.
    always_ff @(posedge spi_sclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_word_idx   <= '0;
            r_wif        <= '0;
            r_bit_cnt    <= '0;
            r_lead_cnt   <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
            r_prefetch   <= '0;
            r_addr_hold  <= '0;
            r_words_sent <= '0;
        end else if (!w_abort) begin
            if (mem_re) r_addr_hold <= w_addr;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_word_idx   <= '0;
                        r_wif        <= '0;
                        r_words_sent <= '0;
                    end
                end
                FETCH: begin
                    r_lead_cnt <= '0;
                end
                LEAD: begin
                    if (r_lead_cnt == '0) r_shift <= mem_rdata;
                    r_lead_cnt <= r_lead_cnt + LEAD_W'(1);
                    r_bit_cnt  <= '0;
                end
                SHIFT: begin
                    r_shift   <= {r_shift[14:0], 1'b0};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    if (r_bit_cnt == 4'd2 && !w_last_in_frame) r_prefetch <= mem_rdata;
                    if (w_bit_end) begin
                        r_words_sent <= r_words_sent + (ADDR_W+1)'(1);
                        if (!w_last_in_frame) begin
                            r_shift    <= r_prefetch;
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                            r_wif      <= r_wif + WIF_W'(1);
                        end else if (!w_is_last_word) begin
                            r_word_idx <= r_word_idx + ADDR_W'(1);
                            r_wif      <= '0;
                            r_gap_cnt  <= '0;
                        end
                    end
                end
                GAP: begin
                    r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_matrix_tx_master.sv
// Bench: two instances (4 and 5 words, 2-word frames) checked cycle by cycle
// against an expected SPI waveform built from the frame/lead/gap rules.
module tb_spi_matrix_tx_master;

    logic        clk;
    logic        rst_n;
    logic [1:0]  st, ab, mre, cs, mosi, busy, done;
    logic [11:0] maddr [2];
    logic [15:0] rdata [2];
    logic [12:0] ws    [2];
    logic [15:0] mem   [2][0:7];

    typedef struct {
        logic [3:0] sig;   // {cs_n, mosi, done, busy}
        int         ws;
    } ent_t;
    ent_t exp_q[$];

    int checks = 0;
    int passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (mre[k]) rdata[k] <= mem[k][maddr[k][2:0]];
    end

    spi_matrix_tx_master #(.NUM_WORDS(4), .FRAME_WORDS(2), .LEAD_CYCLES(2), .GAP_CYCLES(4), .ADDR_W(12)) u4 (
        .spi_sclk(clk), .sys_rst_n(rst_n), .start(st[0]), .abort(ab[0]),
        .mem_re(mre[0]), .mem_addr(maddr[0]), .mem_rdata(rdata[0]),
        .spi_cs_n(cs[0]), .spi_mosi(mosi[0]), .busy(busy[0]), .done(done[0]), .words_sent(ws[0]));

    spi_matrix_tx_master #(.NUM_WORDS(5), .FRAME_WORDS(2), .LEAD_CYCLES(2), .GAP_CYCLES(4), .ADDR_W(12)) u5 (
        .spi_sclk(clk), .sys_rst_n(rst_n), .start(st[1]), .abort(ab[1]),
        .mem_re(mre[1]), .mem_addr(maddr[1]), .mem_rdata(rdata[1]),
        .spi_cs_n(cs[1]), .spi_mosi(mosi[1]), .busy(busy[1]), .done(done[1]), .words_sent(ws[1]));

    task automatic push(input logic [3:0] s, input int n);
        ent_t e;
        e.sig = s;
        e.ws  = n;
        exp_q.push_back(e);
    endtask

    task automatic fill(input int sel, input bit rnd);
        for (int i = 0; i < 8; i++)
            mem[sel][i] = rnd ? 16'($urandom) : 16'hA5C0 + 16'(i);
    endtask

    // Expected waveform: FETCH, 2 lead, 16 bits per word, 4 gap between frames, DONE, IDLE.
    task automatic build(input int sel);
        int nw;
        int n;
        nw = (sel == 0) ? 4 : 5;
        n  = 0;
        exp_q.delete();
        for (int f = 0; f < nw; f += 2) begin
            push(4'b1001, n);
            repeat (2) push(4'b0001, n);
            for (int w = f; w < f + 2 && w < nw; w++) begin
                for (int b = 15; b >= 0; b--) push({1'b0, mem[sel][w][b], 2'b01}, n);
                n++;
            end
            if (f + 2 < nw) repeat (4) push(4'b1001, n);
        end
        push(4'b1011, n);
        push(4'b1000, n);
    endtask

    task automatic check_idle(input int sel, input int cycles, input int want_ws, input string nm);
        for (int c = 0; c < cycles; c++) begin
            checks++;
            if ({cs[sel], mosi[sel], done[sel], busy[sel]} !== 4'b1000 || ws[sel] !== 13'(want_ws))
                $display("FAIL %s idle[%0d] got sig=%b ws=%0d want sig=1000 ws=%0d",
                         nm, c, {cs[sel], mosi[sel], done[sel], busy[sel]}, ws[sel], want_ws);
            else passes++;
            @(negedge clk);
        end
    endtask

    // mode 0: plain run, 1: abort at index cut, 2: reset at index cut
    task automatic run_trace(input int sel, input bit hold, input int mode, input int cut, input string nm);
        st[sel] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if ({cs[sel], mosi[sel], done[sel], busy[sel]} !== exp_q[i].sig || ws[sel] !== 13'(exp_q[i].ws))
                $display("FAIL %s cyc%0d got sig=%b ws=%0d want sig=%b ws=%0d", nm, i,
                         {cs[sel], mosi[sel], done[sel], busy[sel]}, ws[sel], exp_q[i].sig, exp_q[i].ws);
            else passes++;
            if (!hold && i == 0) st[sel] = 1'b0;
            if (hold && i == exp_q.size() - 1) st[sel] = 1'b0;
            if (mode == 1 && i == cut) begin
                ab[sel] = 1'b1;
                @(negedge clk);
                ab[sel] = 1'b0;
                check_idle(sel, 4, exp_q[i].ws, {nm, "_abort"});
                return;
            end
            if (mode == 2 && i == cut) begin
                #2 rst_n = 1'b0;
                #1;
                checks++;
                if ({cs[sel], mosi[sel], mre[sel], busy[sel], done[sel]} !== 5'b10000 ||
                    maddr[sel] !== 12'd0 || ws[sel] !== 13'd0)
                    $display("FAIL %s_rst got cs,mosi,re,busy,done=%b addr=%0d ws=%0d want 10000 0 0",
                             nm, {cs[sel], mosi[sel], mre[sel], busy[sel], done[sel]}, maddr[sel], ws[sel]);
                else passes++;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                check_idle(sel, 3, 0, {nm, "_postrst"});
                return;
            end
            @(negedge clk);
        end
        checks++;
        if (ws[sel] !== 13'(sel == 0 ? 4 : 5))
            $display("FAIL %s words_sent got %0d want %0d", nm, ws[sel], sel == 0 ? 4 : 5);
        else passes++;
        check_idle(sel, 3, sel == 0 ? 4 : 5, {nm, "_after"});
    endtask

    task automatic test_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({cs[k], mosi[k], mre[k], busy[k], done[k]} !== 5'b10000 || maddr[k] !== 12'd0 || ws[k] !== 13'd0)
                $display("FAIL reset%0d got cs,mosi,re,busy,done=%b addr=%0d ws=%0d want 10000 0 0",
                         k, {cs[k], mosi[k], mre[k], busy[k], done[k]}, maddr[k], ws[k]);
            else passes++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill(0, 1'b0); build(0); run_trace(0, 1'b0, 0, 0, "basic4");
        fill(1, 1'b0); build(1); run_trace(1, 1'b0, 0, 0, "short_frame5");
    endtask

    task automatic test_random_data();
        for (int r = 0; r < 3; r++) begin
            fill(r % 2, 1'b1); build(r % 2); run_trace(r % 2, 1'b0, 0, 0, "rand_data");
        end
    endtask

    task automatic test_start_held();
        fill(0, 1'b1); build(0); run_trace(0, 1'b1, 0, 0, "start_held");
    endtask

    task automatic test_abort();
        fill(0, 1'b1); build(0); run_trace(0, 1'b0, 1, 26, "abort_w1b7");
        for (int r = 0; r < 3; r++) begin
            fill(1, 1'b1); build(1);
            run_trace(1, 1'b0, 1, $urandom_range(exp_q.size() - 3, 1), "abort_rand");
        end
    endtask

    task automatic test_start_abort_same();
        @(negedge clk);
        st = 2'b11;
        ab = 2'b11;
        @(negedge clk);
        st = 2'b00;
        ab = 2'b00;
        check_idle(0, 3, 4, "start_abort0");
    endtask

    task automatic test_reset_mid();
        fill(0, 1'b1); build(0);
        run_trace(0, 1'b0, 2, 42 + $urandom_range(15, 0), "rst_mid");
        fill(0, 1'b1); build(0); run_trace(0, 1'b0, 0, 0, "restart");
    endtask

    initial begin
        rst_n = 1'b0;
        st    = 2'b00;
        ab    = 2'b00;
        fill(0, 1'b0);
        fill(1, 1'b0);
        test_reset();
        test_basic();
        test_random_data();
        test_start_held();
        test_abort();
        test_basic();
        test_start_abort_same();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_matrix_tx_master.md
SPI_MATRIX_TX_MASTER -- requirements
Module: spi_matrix_tx_master

Interface
REQ-001 Parameter NUM_WORDS, default 4096, is the number of 16-bit words streamed per transfer.
REQ-002 Parameter FRAME_WORDS, default 16, is the maximum number of words sent under one spi_cs_n low period.
REQ-003 Parameter LEAD_CYCLES, default 2, is the count of spi_cs_n-low cycles before the first data bit of a frame.
REQ-004 Parameter GAP_CYCLES, default 4, is the count of spi_cs_n-high cycles between frames.
REQ-005 Parameter ADDR_W, default 12, is the memory address width.
REQ-006 spi_sclk  in  1  bit clock; all flops on rising edge.
REQ-007 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-008 start  in  1  transfer request, sampled only in IDLE.
REQ-009 abort  in  1  terminates any active transfer.
REQ-010 mem_re  out  1  synchronous SRAM read strobe; mem_rdata valid the cycle after mem_re.
REQ-011 mem_addr  out  ADDR_W  read address.
REQ-012 mem_rdata  in  16  read data.
REQ-013 spi_cs_n  out  1  chip select, active low.
REQ-014 spi_mosi  out  1  serial data, MSB first.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on normal completion.
REQ-017 words_sent  out  ADDR_W+1  count of fully transmitted words.

Function
REQ-018 FSM states are IDLE, FETCH, LEAD, SHIFT, GAP and DONE.
REQ-019 In IDLE, start=1 and abort=0 clears word_idx and words_sent and moves to FETCH; start is ignored in every other state.
REQ-020 FETCH lasts one cycle with mem_re=1 and mem_addr=word_idx, then moves to LEAD.
REQ-021 On LEAD entry, shift_reg captures mem_rdata; spi_cs_n=0, spi_mosi=0 for LEAD_CYCLES cycles, then the FSM moves to SHIFT with bit_cnt=0.
REQ-022 In SHIFT, spi_mosi equals shift_reg[15]; shift_reg shifts left one bit per cycle, so word bit (15-k) is driven in SHIFT cycle k, k=0..15.
REQ-023 At bit_cnt==1 of a word that is not last-in-frame, mem_re pulses one cycle with mem_addr=word_idx+1; at bit_cnt==2 prefetch_reg captures mem_rdata.
REQ-024 At bit_cnt==15, words_sent increments; if the word is not last-in-frame, shift_reg loads prefetch_reg, word_idx increments, bit_cnt wraps to 0, and SHIFT continues with no idle bit.
REQ-025 A word is last-in-frame when word_in_frame==FRAME_WORDS-1 or word_idx==NUM_WORDS-1; the final frame is short when NUM_WORDS is not a multiple of FRAME_WORDS.
REQ-026 After last-in-frame with words remaining, word_idx increments, spi_cs_n=1, and the FSM moves to GAP for GAP_CYCLES cycles, then to FETCH.
REQ-027 After word NUM_WORDS-1, the FSM moves to DONE: spi_cs_n=1, done=1 for exactly one cycle, then IDLE.
REQ-028 abort=1 in any non-IDLE state returns the FSM to IDLE next cycle: spi_cs_n=1, spi_mosi=0, no done, words_sent holds its value; abort beats start.
REQ-029 spi_cs_n=1 and spi_mosi=0 in IDLE, FETCH, GAP and DONE; mem_addr holds its last value when mem_re=0.
REQ-030 Counters do not wrap: words_sent reaches exactly NUM_WORDS; word_idx never exceeds NUM_WORDS-1.

Reset
REQ-031 Reset asserted forces IDLE immediately: spi_cs_n=1, spi_mosi=0, mem_re=0, mem_addr=0, busy=0, done=0, words_sent=0, all internal counters and registers 0.
REQ-032 Reset mid-frame deasserts spi_cs_n asynchronously; after release, the block waits in IDLE for a new start.

Verification (NUM_WORDS=4, FRAME_WORDS=2, LEAD_CYCLES=2, GAP_CYCLES=4, mem[i]=16'hA5C0+i)
REQ-033 Start pulse -> FETCH at addr 0, 2 lead cycles, then 32 contiguous bits A5C0,A5C1 on MOSI; 4 CS-high gap cycles; second frame carries A5C2,A5C3; done pulses once; words_sent=4.
REQ-034 Start held high through the transfer -> exactly one transfer; start asserted in DONE is ignored and a new transfer requires start in IDLE.
REQ-035 Abort at bit 7 of word 1 -> spi_cs_n=1 on the next cycle, no done, words_sent=1, busy=0.
REQ-036 Start and abort in the same IDLE cycle -> busy stays 0 and spi_cs_n stays 1.
REQ-037 NUM_WORDS=5 -> frames of 2, 2 and 1 words; the final frame spans 16 bit-cycles; words_sent=5.
REQ-038 Reset pulse during SHIFT of word 2 -> all outputs at reset values immediately; a subsequent start restarts from addr 0.
